// File: rtl/wfg_record_spi.sv
// SPI recorder: oversamples SCLK/CS_N/SDI on the Wishbone clock, deserialises 8/16/24/32-bit
// frames and presents each word on an AXI-Stream master through a small FIFO.
// Optional build macro: WFG_RECORD_SPI_ERR_EN enables the sticky partial-frame error flag.
module wfg_record_spi #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cfg_en_i,
  input  logic        cfg_cpol_i,
  input  logic        cfg_lsbfirst_i,
  input  logic [1:0]  cfg_dff_i,
  input  logic        spi_sclk_i,
  input  logic        spi_cs_ni,
  input  logic        spi_sdi_i,
  input  logic        wfg_axis_tready_i,
  output logic        wfg_axis_tvalid_o,
  output logic [31:0] wfg_axis_tdata_o,
  output logic        busy_o,
  output logic        overflow_o,
  output logic        frame_err_o
);

  localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = AW + 1;

  typedef enum logic [1:0] {StDisabled, StIdle, StShift} state_e;

  state_e state_q, state_d;

  // [0] first sync FF, [1] synchronised value, [2] history
  logic [2:0] sclk_q, cs_q;
  logic [1:0] sdi_q;

  logic        cpol_q, lsb_q;
  logic [1:0]  dff_q;
  logic [4:0]  cnt_q;
  logic [31:0] sr_q;
  logic        overflow_q, frame_err_q;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  logic sclk_rise, sclk_fall, sample_edge, cs_fall, cs_rise, sdi_bit;
  logic shift_en, word_done, fifo_full, push_ok, pop;
  logic [31:0] sr_next;

  // Pin synchronisers; reset to 0 so a CS_N already low at release never looks like a fresh fall
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sclk_q <= '0;
      cs_q   <= '0;
      sdi_q  <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_sclk_i};
      cs_q   <= {cs_q[1:0], spi_cs_ni};
      sdi_q  <= {sdi_q[0], spi_sdi_i};
    end
  end

  assign sclk_rise   = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall   = ~sclk_q[1] & sclk_q[2];
  assign cs_fall     = ~cs_q[1] & cs_q[2];
  assign cs_rise     = cs_q[1] & ~cs_q[2];
  assign sdi_bit     = sdi_q[1];
  assign sample_edge = cpol_q ? sclk_fall : sclk_rise;

  assign shift_en  = cfg_en_i && (state_q == StShift) && sample_edge;
  assign word_done = shift_en && (cnt_q == {dff_q, 3'b111});
  // The shift register is cleared per frame, so OR-ing the LSB-first bit in is sufficient
  assign sr_next   = lsb_q ? (sr_q | (32'(sdi_bit) << cnt_q)) : {sr_q[30:0], sdi_bit};

  // FSM state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= StDisabled;
    else            state_q <= state_d;
  end

  // FSM next state; disable overrides everything
  always_comb begin
    state_d = state_q;
    if (!cfg_en_i) begin
      state_d = StDisabled;
    end else begin
      unique case (state_q)
        StDisabled: state_d = StIdle;
        StIdle:     if (cs_fall) state_d = StShift;
        StShift:    if (cs_rise) state_d = StIdle;
        default:    state_d = StDisabled;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    busy_o = (state_q == StShift);
  end

`ifdef WFG_RECORD_SPI_ERR_EN
  logic [4:0] cnt_after;
  logic       frame_abort;
  assign cnt_after   = shift_en ? (word_done ? 5'd0 : cnt_q + 5'd1) : cnt_q;
  assign frame_abort = cfg_en_i && (state_q == StShift) && cs_rise && (cnt_after != 5'd0);
`endif

  // Deserialiser, frame configuration capture and sticky flags
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cpol_q      <= 1'b0;
      lsb_q       <= 1'b0;
      dff_q       <= 2'b00;
      cnt_q       <= '0;
      sr_q        <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else if (!cfg_en_i) begin
      cnt_q       <= '0;
      sr_q        <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (state_q == StIdle && cs_fall) begin
        cpol_q <= cfg_cpol_i;
        lsb_q  <= cfg_lsbfirst_i;
        dff_q  <= cfg_dff_i;
        cnt_q  <= '0;
        sr_q   <= '0;
      end else if (shift_en) begin
        cnt_q <= word_done ? 5'd0 : cnt_q + 5'd1;
        sr_q  <= word_done ? 32'd0 : sr_next;
      end
      if (word_done && fifo_full && !pop) overflow_q <= 1'b1;
`ifdef WFG_RECORD_SPI_ERR_EN
      if (frame_abort) frame_err_q <= 1'b1;
`endif
    end
  end

  assign fifo_full = (count_q == CntW'(FIFO_DEPTH));
  assign pop       = wfg_axis_tvalid_o && wfg_axis_tready_i;
  // A simultaneous pop frees the slot, so a push into a full FIFO is still taken
  assign push_ok   = word_done && (!fifo_full || pop);

  // FIFO storage; contents are only visible through valid entries, so no reset is needed
  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= sr_next;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (!cfg_en_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop)      count_q <= count_q + CntW'(1);
      else if (!push_ok && pop) count_q <= count_q - CntW'(1);
    end
  end

  assign wfg_axis_tvalid_o = (count_q != '0);
  assign wfg_axis_tdata_o  = wfg_axis_tvalid_o ? mem_q[rd_ptr_q] : 32'd0;
  assign overflow_o        = overflow_q;
`ifdef WFG_RECORD_SPI_ERR_EN
  assign frame_err_o       = frame_err_q;
`else
  assign frame_err_o       = 1'b0;
`endif

endmodule
